// File: rtl/timer_pkg.sv
// Shared types and limits for the wash timer low-digit countdown.
// State encoding, BCD digit limits and a small clamp helper.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // One M:SS display worth of BCD digits.
    typedef struct packed {
        logic [3:0] mins;
        logic [3:0] st;
        logic [3:0] so;
    } digits_t;

    function automatic logic [3:0] clamp_digit(
        input logic [3:0] v,
        input logic [3:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/wash_timer_low_digits_if.sv
// Control and display bundle between the wash controller and the
// low-digit timer; the controller is master, the timer is slave.
interface wash_timer_low_digits_if;

    logic       start;
    logic [3:0] load_ones;
    logic       pause;
    logic [3:0] tens_count;
    logic [3:0] ones_min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       bout;
    logic       running;
    logic       done;

    modport master (
        output start, load_ones, pause, tens_count,
        input  ones_min, sec_tens, sec_ones, bout, running, done
    );

    modport slave (
        input  start, load_ones, pause, tens_count,
        output ones_min, sec_tens, sec_ones, bout, running, done
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick every TICK_DIV
// enabled cycles; the count is retained while disabled.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Next count: clear on load, wrap on tick, hold when disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wash_timer_low_digits.sv
// Ones-minute and seconds BCD down-counter of the wash/dry countdown,
// with borrow-out to the tens-minute stage and end-of-cycle detect.
module wash_timer_low_digits
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter logic [3:0]  MAX_ONES = 4'd9
) (
    input  logic CLK100MHZ,
    input  logic reset,
    wash_timer_low_digits_if.slave bus
);

    state_t  state_q;
    digits_t dig_q;
    digits_t dec_d;
    logic    bout_q;
    logic    running_q;
    logic    done_q;

    logic tick;
    logic load;
    logic zero;

    // Start is honoured only when no countdown is in progress.
    assign load = bus.start && ((state_q == IDLE) || (state_q == DONE));

    assign zero = (dig_q.mins == 4'd0) &&
                  (dig_q.st == 4'd0) &&
                  (dig_q.so == 4'd0);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .clk_i (CLK100MHZ),
        .rst_i (reset),
        .clr_i (load),
        .en_i  (state_q == RUN),
        .tick_o(tick)
    );

    // One-second BCD decrement with seconds and minute borrows.
    always_comb begin
        dec_d = dig_q;
        if (dig_q.so != 4'd0) begin
            dec_d.so = dig_q.so - 4'd1;
        end else if (dig_q.st != 4'd0) begin
            dec_d.so = DIGIT_MAX;
            dec_d.st = dig_q.st - 4'd1;
        end else begin
            dec_d.so   = DIGIT_MAX;
            dec_d.st   = SEC_TENS_MAX;
            dec_d.mins = dig_q.mins - 4'd1;
        end
    end

    // Control FSM with registered digits and status outputs.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q   <= IDLE;
            dig_q     <= '0;
            bout_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bout_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (load) begin
                        dig_q.mins <= clamp_digit(bus.load_ones, MAX_ONES);
                        dig_q.st   <= 4'd0;
                        dig_q.so   <= 4'd0;
                        state_q    <= RUN;
                        running_q  <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (tick && zero && (bus.tens_count == 4'd0)) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        if (tick && zero) begin
                            dig_q.mins <= DIGIT_MAX;
                            dig_q.st   <= SEC_TENS_MAX;
                            dig_q.so   <= DIGIT_MAX;
                            bout_q     <= 1'b1;
                        end else if (tick) begin
                            dig_q <= dec_d;
                        end
                        if (bus.pause) begin
                            state_q <= PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    if (!bus.pause) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ones_min = dig_q.mins;
    assign bus.sec_tens = dig_q.st;
    assign bus.sec_ones = dig_q.so;
    assign bus.bout     = bout_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;

endmodule

// File: doc/wash_timer_low_digits.md
Name: wash_timer_low_digits

Overview:
- Generates the ones-minute and seconds digits of the wash/dry countdown (M:SS below the tens-minute digit).
- Sits directly upstream of the tens-minute down-counter stage.
- Prescales CLK100MHZ to a 1 s tick and runs the seconds and ones-minute digits as a BCD down-counter.
- Emits the borrow pulse that the tens stage edge-detects on its borrow-in, and declares end of cycle when all digits reach zero.

Parameters:
- TICK_DIV, 100_000_000: CLK100MHZ cycles per seconds tick; the bench sets it to 4.
- MAX_ONES, 9: clamp value for the ones-minute load.

Ports:
- CLK100MHZ  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle load/start pulse, issued in the same cycle the tens stage loads its digit.
- load_ones  input  4  ones-minute value captured on start.
- pause  input  1  level; while high, the prescaler and digits hold.
- tens_count  input  4  current tens-minute digit from the downstream stage.
- ones_min  output  4  ones-minute BCD digit.
- sec_tens  output  4  seconds tens BCD digit, 0..5.
- sec_ones  output  4  seconds units BCD digit, 0..9.
- bout  output  1  borrow-out to the tens stage borrow-in; one-cycle high pulse.
- running  output  1  high in RUN and PAUSE.
- done  output  1  high in DONE.

Behaviour:
- Reset: state=IDLE; prescaler=0; ones_min, sec_tens, sec_ones = 0; bout=0; running=0; done=0. Reset overrides every other input, including mid-run.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - On start: ones_min <= min(load_ones, MAX_ONES); sec_tens=0; sec_ones=0; prescaler=0; go to RUN the next cycle.
  - start has priority over pause in the same cycle.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. tick is asserted in the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - On tick, with Z = (ones_min==0 && sec_tens==0 && sec_ones==0):
  - If Z and tens_count==0: go to DONE; digits hold at 0:00; no bout.
  - Else if Z: ones_min=9, sec_tens=5, sec_ones=9, and bout=1 for exactly that one cycle. The tens stage decrements on bout's rising edge.
  - Else, normal BCD decrement:
    - sec_ones 0 wraps to 9 with a seconds-tens borrow.
    - sec_tens 0 wraps to 5 with a ones-minute borrow.
  - The first first-tick latency after start is TICK_DIV cycles.
- pause:
  - pause=1 in RUN: go to PAUSE; prescaler and digits frozen, prescaler value retained.
  - pause=0 in PAUSE: back to RUN, resuming from the retained prescaler value.
  - If tick and pause rise in the same cycle, the tick is processed first, then the block enters PAUSE.
- start while RUN or PAUSE: ignored.
- DONE:
  - Holds done=1 and digits 0:00.
  - start reloads exactly as in IDLE and enters RUN; done drops the next cycle.
- bout:
  - Never asserted in consecutive cycles, so the tens stage always sees a 0→1 edge.
  - bout is 0 in every state except the RUN tick cycle.
- Width/clamping:
  - load_ones values 10..15 clamp to MAX_ONES.
  - Digits never leave BCD range: sec_tens ≤ 5, others ≤ 9.
- Outputs are registered: running, done and the digits update the cycle after the causing event.

Decomposition:
- Shared package timer_pkg: state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3) and BCD limit constants (SEC_TENS_MAX=5, DIGIT_MAX=9).
- One natural sub-module: tick_prescaler, a parameterized TICK_DIV counter with an enable input and a tick output.
- BCD digit logic and the FSM stay in the top module.

Test Plan:
1. Reset mid-run: reset=1 while showing 4:17 → next cycle all outputs are 0, state IDLE; bout never pulses.
2. start, load_ones=2, tens_count=3, TICK_DIV=4 → first tick at cycle 4 gives 1:59, no bout. After 120 ticks the digits read 0:00. The next tick gives 9:59 with a single-cycle bout.
3. load_ones=0, tens_count=0, start → after one tick (4 cycles): done=1, running=0, digits 0:00, bout stays 0.
4. pause asserted for 10 cycles at prescaler=2 showing 0:45 → digits and prescaler frozen. After release, the next tick arrives exactly 2 cycles later and shows 0:44.
5. start with load_ones=13 → ones_min=9. Also, start asserted while RUN → no reload.
6. Simultaneous start and pause in IDLE → enters RUN (start wins), then PAUSE the following cycle because pause is still high; digits stay at the loaded value.
